dtc_tree_engine: RTL and testbench

- Programmable, sequential decision-tree classifier; successor to the fixed combinational per-model dtc blocks.
- The tree is a complete binary tree of parametrised depth. Each internal node stores an input-feature index; each leaf stores a class word.
- The table is loaded at run time through a config write port.
- Classification walks one tree level per clock and uses valid/ready handshakes on input and output. It sits between the feature-extraction stage and the result consumer.

---
 rtl/dtc_tree_engine_if.sv | 28 ++
 rtl/dtc_tree_engine.sv | 92 +++++++++
 tb/tb_dtc_tree_engine.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dtc_tree_engine_if.sv
// Handshake and config bus for the decision-tree engine.
// master = feature producer / result consumer / config host, slave = engine.
interface dtc_tree_engine_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int DEPTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  inp;
  logic [OUT_W-1:0] outp;
  logic             out_valid;
  logic             out_ready;
  logic             cfg_we;
  logic [DEPTH:0]   cfg_addr;
  logic [OUT_W-1:0] cfg_wdata;
  logic             cfg_err;

  modport master (
    output in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, outp, out_valid, cfg_err
  );

  modport slave (
    input  in_valid, inp, out_ready, cfg_we, cfg_addr, cfg_wdata,
    output in_ready, outp, out_valid, cfg_err
  );
endinterface

// File: rtl/dtc_tree_engine.sv
// Programmable decision-tree classifier: walks one level of a complete binary
// tree per clock, with a flop-based node/leaf table loaded through a config port.
module dtc_tree_engine #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  dtc_tree_engine_if.slave bus
);
  localparam int FEAT_W = $clog2(IN_W);
  localparam int N      = (1 << DEPTH) - 1;
  localparam int L      = 1 << DEPTH;
  localparam int ADDR_W = DEPTH + 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t            state, state_nxt;
  logic [FEAT_W-1:0] node_feat [N];
  logic [OUT_W-1:0]  leaf      [L];
  logic [IN_W-1:0]   vec_q;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [LVL_W-1:0]  lvl;
  logic [DEPTH-1:0]  node_sel, leaf_sel, cfg_node, cfg_leaf;
  logic [OUT_W-1:0]  outp_q;
  logic              b, last, addr_bad, cfg_err_q;

  // Heap layout: children of node i are 2i+1 (bit=0) and 2i+2 (bit=1).
  assign node_sel = idx[DEPTH-1:0];
  assign b        = vec_q[node_feat[node_sel]];
  assign idx_nxt  = (idx << 1) + ADDR_W'(1) + ADDR_W'(b);
  assign leaf_sel = DEPTH'(idx_nxt - ADDR_W'(N));
  assign last     = (lvl == LVL_W'(DEPTH - 1));

  assign cfg_node = bus.cfg_addr[DEPTH-1:0];
  assign cfg_leaf = DEPTH'(bus.cfg_addr - ADDR_W'(N));
  assign addr_bad = (bus.cfg_addr >= ADDR_W'(N + L));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.outp      = outp_q;
  assign bus.cfg_err   = cfg_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = WALK;
      WALK:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      idx       <= '0;
      lvl       <= '0;
      outp_q    <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < N; i++) node_feat[i] <= '0;
      for (int i = 0; i < L; i++) leaf[i]      <= '0;
    end else begin
      // Table only changes while idle so a walk sees a frozen tree.
      cfg_err_q <= bus.cfg_we && (state != IDLE || addr_bad);
      if (bus.cfg_we && state == IDLE && !addr_bad) begin
        if (bus.cfg_addr < ADDR_W'(N)) node_feat[cfg_node] <= bus.cfg_wdata[FEAT_W-1:0];
        else                           leaf[cfg_leaf]      <= bus.cfg_wdata;
      end
      case (state)
        IDLE: if (bus.in_valid) begin
          vec_q <= bus.inp;
          idx   <= '0;
          lvl   <= '0;
        end
        WALK: begin
          idx <= idx_nxt;
          lvl <= lvl + LVL_W'(1);
          if (last) outp_q <= leaf[leaf_sel];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dtc_tree_engine.sv
// Directed bench for dtc_tree_engine (DEPTH=3, IN_W=8, OUT_W=8).
module tb_dtc_tree_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dtc_tree_engine_if #(.IN_W(8), .OUT_W(8), .DEPTH(3)) bus ();

  dtc_tree_engine #(.IN_W(8), .OUT_W(8), .DEPTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  // Called just after the accept edge; checks exact latency, result, and drains.
  task automatic finish_walk(input logic [7:0] exp, input string tag);
    repeat (2) @(posedge clk);
    @(negedge clk); chk({tag, "_early"}, bus.out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"},  bus.out_valid, 1'b1);
    chk({tag, "_outp"}, bus.outp, exp);
    @(posedge clk); #1;
  endtask

  task automatic classify(input logic [7:0] v, input logic [7:0] exp, input string tag);
    bus.in_valid = 1'b1; bus.inp = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    finish_walk(exp, tag);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.inp = '0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;

    // Reset defaults
    #12;
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_outp",      bus.outp,      8'h00);
    chk("rst_cfg_err",   bus.cfg_err,   1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    classify(8'hFF, 8'h00, "empty_tbl");

    // Heap walk: all features 0, leaf k = 0x11*k
    for (int k = 0; k < 8; k++) cfg_write(4'(7 + k), 8'(8'h11 * k));
    classify(8'h00, 8'h00, "heap_00");
    classify(8'h01, 8'h77, "heap_01");

    // Reset asserted mid-walk clears output and table
    bus.in_valid = 1'b1; bus.inp = 8'h01;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  bus.in_ready,  1'b1);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_outp",      bus.outp,      8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    classify(8'hFF, 8'h00, "tbl_cleared");

    // Mixed features
    cfg_write(4'd0,  8'd7);
    cfg_write(4'd2,  8'd6);
    cfg_write(4'd6,  8'd0);
    cfg_write(4'd14, 8'hA5);
    classify(8'hC1, 8'hA5, "mixed_c1");
    classify(8'hC0, 8'h00, "mixed_c0");

    // Config write during WALK is dropped with a one-cycle error pulse
    bus.in_valid = 1'b1; bus.inp = 8'hC1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd14; bus.cfg_wdata = 8'h5A;
    @(posedge clk); #1 bus.cfg_we = 1'b0;
    @(negedge clk); chk("walk_err_pulse", bus.cfg_err, 1'b1);
    @(posedge clk);
    @(negedge clk); chk("walk_err_clear", bus.cfg_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("walk_wr_vld",  bus.out_valid, 1'b1);
    chk("walk_wr_outp", bus.outp, 8'hA5);
    @(posedge clk); #1;
    classify(8'hC1, 8'hA5, "walk_wr_dropped");

    // Out-of-range address in IDLE
    cfg_write(4'd15, 8'hFF);
    @(negedge clk); chk("badaddr_err", bus.cfg_err, 1'b1);
    @(posedge clk);
    @(negedge clk); chk("badaddr_err_clear", bus.cfg_err, 1'b0);
    @(posedge clk); #1;
    classify(8'h00, 8'h00, "badaddr_nochg");

    // Backpressure: held result, in_valid ignored while DONE
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.inp = 8'hC1;
    @(posedge clk); #1 bus.inp = 8'hC0;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_vld",   bus.out_valid, 1'b1);
      chk("bp_outp",  bus.outp,      8'hA5);
      chk("bp_ready", bus.in_ready,  1'b0);
      @(posedge clk);
    end
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_drain_vld",   bus.out_valid, 1'b0);
    chk("bp_drain_outp",  bus.outp,      8'hA5);
    chk("bp_drain_ready", bus.in_ready,  1'b1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    finish_walk(8'h00, "bp_next");

    // Same-edge node write and accept: root now tests bit 3
    cfg_write(4'd11, 8'h3C);
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_wdata = 8'd3;
    bus.in_valid = 1'b1; bus.inp = 8'h08;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk); chk("same_edge_no_err", bus.cfg_err, 1'b0);
    finish_walk(8'h3C, "same_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
